tt_lq_retire: RTL and testbench
===============================

Name: tt_lq_retire

Overview:
- Response-side counterpart of the memory request path. The LSU issues requests tagged with mem_lqid.
- This block allocates those load-queue IDs in program order and stores an lq_info_s per ID.
- It accepts memory responses, which may arrive out of order and are tagged with the same lqid.
- It retires entries strictly in order to the RF/VRF writeback stage, using a valid/ready handshake.

Parameters:
- LQ_DEPTH, 8 (tt_briscv_pkg::LQ_DEPTH): number of entries; must be a power of 2 and at least 2.
- DATA_W, 32: width of scalar load return data.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_alloc_vld  in  1  allocation request from the issue stage.
- o_alloc_rdy  out  1  a free entry exists.
- i_alloc_info  in  lq_info_s  info for the allocated entry.
- o_alloc_lqid  out  LQ_DEPTH_LOG2  ID granted; valid while o_alloc_rdy is high.
- i_resp_vld  in  1  memory response valid; always accepted.
- i_resp_lqid  in  LQ_DEPTH_LOG2  ID of the response.
- i_resp_data  in  DATA_W  load data, already sized and sign-extended by the memory side.
- o_resp_err  out  1  one-cycle pulse: response hit an invalid or already-done entry.
- o_ret_vld  out  1  head entry is done.
- i_ret_rdy  in  1  writeback accepts the head entry.
- o_ret_info  out  lq_info_s  head entry info.
- o_ret_data  out  DATA_W  head entry data.
- o_lq_count  out  LQ_DEPTH_LOG2+1  number of occupied entries.
- o_lq_empty  out  1  o_lq_count == 0.

Behaviour:
- Storage: a circular buffer with wr_ptr and rd_ptr, each LQ_DEPTH_LOG2+1 bits wide (extra bit is the wrap bit). Each entry holds a valid bit, a done bit, info, and data.
- Reset: pointers 0, all valid/done bits 0, data 0. Outputs after reset: o_alloc_rdy=1, o_alloc_lqid=0, o_ret_vld=0, o_resp_err=0, o_lq_count=0, o_lq_empty=1.
  - Reset asserted mid-operation discards all entries.
  - Responses arriving after reset for pre-reset IDs flag o_resp_err.
- Allocation, when i_alloc_vld && o_alloc_rdy:
  - entry[wr_ptr] gets valid=1 and info=i_alloc_info; wr_ptr increments.
  - o_alloc_lqid = wr_ptr[LQ_DEPTH_LOG2-1:0].
  - done is set at allocation (data cleared to 0) when info.load==0, or when (info.vec_load && info.vl_is_zero), or when info.squash_vec_wr_flag==1. Otherwise done=0.
- o_alloc_rdy = (count < LQ_DEPTH), computed from registered state only. There is no bypass of a same-cycle retire: when full, a slot freed by a retire can be allocated in the next cycle.
- Response, when i_resp_vld:
  - If entry[i_resp_lqid] is valid and not done: set done=1 and data=i_resp_data, effective from the next cycle.
  - Otherwise: no state change; o_resp_err pulses high in the next cycle (registered).
- Retire:
  - o_ret_vld = entry[rd_ptr].valid && entry[rd_ptr].done, driven from flops only.
  - Latency: a response or done-at-allocation in cycle N gives earliest o_ret_vld in cycle N+1.
  - On o_ret_vld && i_ret_rdy, clear valid and done at the head and increment rd_ptr.
  - While i_ret_rdy=0, o_ret_info and o_ret_data hold stable.
- Simultaneous events:
  - Alloc, resp and retire in the same cycle are all legal and update independently.
  - A response to the head entry and a retire in the same cycle cannot collide: retire requires done, and a response to a done entry is an error.
  - Count update: count + alloc_fire - ret_fire.
- Wrap: an ID is reused only after it has retired. Full is detected as pointer indices equal with wrap bits differing; empty as both equal.
- Ordering: retire order equals allocation order regardless of response order.

Decomposition:
- Shared in tt_briscv_pkg: lq_info_s, LQ_DEPTH, LQ_DEPTH_LOG2 (existing); a new typedef lq_entry_s {valid, done, lq_info_s info, logic [31:0] data}.
- One natural sub-module: tt_lq_ptr, a wrap-bit pointer/count tracker providing full, empty and count. Entry array and control stay in tt_lq_retire.

Test Plan:
- Reset: hold i_reset 2 cycles -> o_alloc_rdy=1, o_alloc_lqid=0, o_ret_vld=0, o_lq_empty=1, o_lq_count=0.
- Out-of-order return: alloc 3 loads (IDs 0,1,2); respond lqid 2 with 0xC, then 0 with 0xA, then 1 with 0xB on consecutive cycles -> o_ret_vld rises one cycle after the lqid 0 response; retires in order 0xA, 0xB, 0xC.
- Full/wrap: allocate 8 -> o_lq_count=8, o_alloc_rdy=0. In the same cycle, retire the head and request an alloc -> alloc is not taken; next cycle o_alloc_rdy=1 with o_alloc_lqid=0 (reused), then wr_ptr wraps.
- Done at alloc: alloc an entry with load=0 (branch tracking) and a vec_load entry with vl_is_zero=1 -> both retire on consecutive cycles with no response, o_ret_data=0.
- Error: response to unallocated lqid 5 -> o_resp_err=1 for exactly one cycle, count unchanged. A second response to an already-done entry -> error again, data unchanged.
- Backpressure/reset: hold i_ret_rdy=0 for 5 cycles with the head done -> o_ret_info/o_ret_data stable. Assert i_reset with 4 entries occupied -> next cycle empty; a late response flags o_resp_err.

Source files
------------

// File: rtl/tt_briscv_pkg.sv
// Shared load-queue types and sizing for the scalar/vector load return path.
package tt_briscv_pkg;

  localparam int unsigned LQ_DEPTH      = 8;
  localparam int unsigned LQ_DEPTH_LOG2 = $clog2(LQ_DEPTH);
  localparam int unsigned LQ_DATA_W     = 32;

  typedef struct packed {
    logic       load;
    logic       vec_load;
    logic       vl_is_zero;
    logic       squash_vec_wr_flag;
    logic [1:0] size;
    logic [4:0] rd;
  } lq_info_s;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    lq_info_s             info;
    logic [LQ_DATA_W-1:0] data;
  } lq_entry_s;

  // Entries that never receive a memory response are complete as soon as they are allocated.
  function automatic logic lq_done_at_alloc(lq_info_s info);
    return !info.load || (info.vec_load && info.vl_is_zero) || info.squash_vec_wr_flag;
  endfunction

endpackage

// File: rtl/tt_lq_ptr.sv
// Wrap-bit read/write pointer pair giving full, empty and occupancy for a power-of-2 queue.
module tt_lq_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_inc,
  input  logic          i_rd_inc,
  output logic [AW-1:0] o_wr_idx,
  output logic [AW-1:0] o_rd_idx,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PW = AW + 1;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_inc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_rd_inc) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  assign o_wr_idx = r_wr_ptr[AW-1:0];
  assign o_rd_idx = r_rd_ptr[AW-1:0];
  assign o_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  // Modular difference is exact because the wrap bit doubles the pointer range.
  assign o_count  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/tt_lq_retire.sv
// Load queue: in-order lqid allocation, out-of-order response capture, in-order retire to writeback.
module tt_lq_retire
  import tt_briscv_pkg::*;
#(
  parameter int unsigned DEPTH  = LQ_DEPTH,
  parameter int unsigned DATA_W = LQ_DATA_W,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_alloc_vld,
  output logic              o_alloc_rdy,
  input  lq_info_s          i_alloc_info,
  output logic [AW-1:0]     o_alloc_lqid,
  input  logic              i_resp_vld,
  input  logic [AW-1:0]     i_resp_lqid,
  input  logic [DATA_W-1:0] i_resp_data,
  output logic              o_resp_err,
  output logic              o_ret_vld,
  input  logic              i_ret_rdy,
  output lq_info_s          o_ret_info,
  output logic [DATA_W-1:0] o_ret_data,
  output logic [AW:0]       o_lq_count,
  output logic              o_lq_empty
);

  lq_entry_s       r_entries [DEPTH];
  logic            r_resp_err;

  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;
  logic            w_full;
  logic            w_empty;
  logic [AW:0]     w_count;
  logic            w_alloc_fire;
  logic            w_ret_fire;
  logic            w_resp_hit;
  logic            w_resp_ok;
  lq_entry_s       w_head;

  tt_lq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_inc (w_alloc_fire),
    .i_rd_inc (w_ret_fire),
    .o_wr_idx (w_wr_idx),
    .o_rd_idx (w_rd_idx),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_head       = r_entries[w_rd_idx];
  assign w_alloc_fire = i_alloc_vld && !w_full;
  assign w_ret_fire   = o_ret_vld && i_ret_rdy;
  assign w_resp_hit   = r_entries[i_resp_lqid].valid && !r_entries[i_resp_lqid].done;
  assign w_resp_ok    = i_resp_vld && w_resp_hit;

  // Alloc, response and retire touch distinct entries whenever each can fire, so all three apply together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_resp_err <= i_resp_vld && !w_resp_hit;
      if (w_ret_fire) begin
        r_entries[w_rd_idx].valid <= 1'b0;
        r_entries[w_rd_idx].done  <= 1'b0;
      end
      if (w_resp_ok) begin
        r_entries[i_resp_lqid].done <= 1'b1;
        r_entries[i_resp_lqid].data <= LQ_DATA_W'(i_resp_data);
      end
      if (w_alloc_fire) begin
        r_entries[w_wr_idx].valid <= 1'b1;
        r_entries[w_wr_idx].done  <= lq_done_at_alloc(i_alloc_info);
        r_entries[w_wr_idx].info  <= i_alloc_info;
        r_entries[w_wr_idx].data  <= '0;
      end
    end
  end

  assign o_alloc_rdy  = !w_full;
  assign o_alloc_lqid = w_wr_idx;
  assign o_resp_err   = r_resp_err;
  assign o_ret_vld    = w_head.valid && w_head.done;
  assign o_ret_info   = w_head.info;
  assign o_ret_data   = DATA_W'(w_head.data);
  assign o_lq_count   = w_count;
  assign o_lq_empty   = w_empty;

endmodule

// File: tb/tb_tt_lq_retire.sv
// Bench for tt_lq_retire: queue-based reference model checked every cycle, directed cases plus random traffic.
module tb_tt_lq_retire;
  import tt_briscv_pkg::*;

  localparam int unsigned D  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_alloc_vld;
  logic          o_alloc_rdy;
  lq_info_s      i_alloc_info;
  logic [AW-1:0] o_alloc_lqid;
  logic          i_resp_vld;
  logic [AW-1:0] i_resp_lqid;
  logic [31:0]   i_resp_data;
  logic          o_resp_err;
  logic          o_ret_vld;
  logic          i_ret_rdy;
  lq_info_s      o_ret_info;
  logic [31:0]   o_ret_data;
  logic [AW:0]   o_lq_count;
  logic          o_lq_empty;

  tt_lq_retire dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_alloc_vld(i_alloc_vld), .o_alloc_rdy(o_alloc_rdy), .i_alloc_info(i_alloc_info),
    .o_alloc_lqid(o_alloc_lqid),
    .i_resp_vld(i_resp_vld), .i_resp_lqid(i_resp_lqid), .i_resp_data(i_resp_data),
    .o_resp_err(o_resp_err),
    .o_ret_vld(o_ret_vld), .i_ret_rdy(i_ret_rdy), .o_ret_info(o_ret_info), .o_ret_data(o_ret_data),
    .o_lq_count(o_lq_count), .o_lq_empty(o_lq_empty)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: program-ordered list of outstanding loads.
  typedef struct {
    int          id;
    lq_info_s    info;
    bit          done;
    logic [31:0] data;
  } mrec_t;

  mrec_t mq[$];
  int    next_id = 0;
  bit    m_err   = 0;
  bit    m_init  = 0;

  always @(posedge clk) begin
    if (i_reset) begin
      mq.delete();
      next_id = 0;
      m_err   = 0;
      m_init  = 1;
    end else if (m_init) begin
      bit ret, alloc, found, already;
      int k;
      ret     = (mq.size() > 0) && mq[0].done && i_ret_rdy;
      alloc   = i_alloc_vld && (mq.size() < D);
      found   = 0;
      already = 0;
      k       = -1;
      foreach (mq[j]) if (mq[j].id == int'(i_resp_lqid)) begin found = 1; k = j; end
      if (found) already = mq[k].done;
      m_err = i_resp_vld && (!found || already);
      if (i_resp_vld && found && !already) begin
        mq[k].done = 1;
        mq[k].data = i_resp_data;
      end
      if (ret) void'(mq.pop_front());
      if (alloc) begin
        mrec_t r;
        r.id   = next_id;
        r.info = i_alloc_info;
        r.done = (i_alloc_info.load == 1'b0) ||
                 (i_alloc_info.vec_load && i_alloc_info.vl_is_zero) ||
                 i_alloc_info.squash_vec_wr_flag;
        r.data = 32'h0;
        mq.push_back(r);
        next_id = (next_id + 1) % D;
      end
    end
    #1;
    if (m_init) begin
      bit hv;
      hv = (mq.size() > 0) && mq[0].done;
      chk("count",   64'(o_lq_count),  64'(mq.size()));
      chk("empty",   64'(o_lq_empty),  64'(mq.size() == 0));
      chk("alloc_rdy", 64'(o_alloc_rdy), 64'(mq.size() < D));
      if (mq.size() < D) chk("alloc_lqid", 64'(o_alloc_lqid), 64'(next_id));
      chk("ret_vld", 64'(o_ret_vld),   64'(hv));
      chk("resp_err", 64'(o_resp_err), 64'(m_err));
      if (hv) begin
        chk("ret_info", 64'(o_ret_info), 64'(mq[0].info));
        chk("ret_data", 64'(o_ret_data), 64'(mq[0].data));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic lq_info_s mk(bit ld, bit vl, bit vz, bit sq, logic [4:0] rd);
    lq_info_s r;
    r.load = ld; r.vec_load = vl; r.vl_is_zero = vz; r.squash_vec_wr_flag = sq;
    r.size = 2'd2; r.rd = rd;
    return r;
  endfunction

  task automatic resp(input logic [AW-1:0] id, input logic [31:0] d);
    i_resp_vld = 1; i_resp_lqid = id; i_resp_data = d;
  endtask

  lq_info_s info_bp;

  initial begin
    i_reset = 1; i_alloc_vld = 0; i_alloc_info = '0; i_resp_vld = 0;
    i_resp_lqid = '0; i_resp_data = '0; i_ret_rdy = 0;
    step(); step();
    chk("rst_rdy",   64'(o_alloc_rdy), 64'(1));
    chk("rst_lqid",  64'(o_alloc_lqid), 64'(0));
    chk("rst_retv",  64'(o_ret_vld), 64'(0));
    chk("rst_empty", 64'(o_lq_empty), 64'(1));
    chk("rst_count", 64'(o_lq_count), 64'(0));
    i_reset = 0;

    // Out-of-order responses, in-order retire
    i_alloc_info = mk(1, 0, 0, 0, 5'd1);
    for (int i = 0; i < 3; i++) begin
      i_alloc_vld = 1;
      chk("ooo_lqid", 64'(o_alloc_lqid), 64'(i));
      step();
    end
    i_alloc_vld = 0;
    resp(2, 32'hC); step();
    chk("ooo_notyet", 64'(o_ret_vld), 64'(0));
    resp(0, 32'hA); step();
    chk("ooo_rise", 64'(o_ret_vld), 64'(1));
    resp(1, 32'hB); step();
    i_resp_vld = 0; i_ret_rdy = 1;
    chk("ooo_d0", 64'(o_ret_data), 64'(32'hA)); step();
    chk("ooo_d1", 64'(o_ret_data), 64'(32'hB)); step();
    chk("ooo_d2", 64'(o_ret_data), 64'(32'hC)); step();
    i_ret_rdy = 0;
    chk("ooo_empty", 64'(o_lq_empty), 64'(1));

    // Full and wrap
    i_reset = 1; step(); i_reset = 0;
    i_alloc_vld = 1;
    for (int i = 0; i < 8; i++) begin
      i_alloc_info = mk(1, 0, 0, 0, 5'(i));
      step();
    end
    i_alloc_vld = 0;
    chk("full_count", 64'(o_lq_count), 64'(8));
    chk("full_rdy",   64'(o_alloc_rdy), 64'(0));
    resp(0, 32'h100); step();
    i_resp_vld = 0; i_ret_rdy = 1; i_alloc_vld = 1; step();
    chk("wrap_count", 64'(o_lq_count), 64'(7));
    chk("wrap_rdy",   64'(o_alloc_rdy), 64'(1));
    chk("wrap_lqid",  64'(o_alloc_lqid), 64'(0));
    i_ret_rdy = 0; step();
    i_alloc_vld = 0;
    chk("wrap_refull", 64'(o_lq_count), 64'(8));
    i_ret_rdy = 1;
    for (int i = 1; i < 8; i++) begin resp(AW'(i), 32'h200 + 32'(i)); step(); end
    resp(0, 32'h300); step();
    i_resp_vld = 0; step(); step();
    chk("wrap_drained", 64'(o_lq_empty), 64'(1));

    // Done at allocation
    i_alloc_vld = 1; i_alloc_info = mk(0, 0, 0, 0, 5'd3); step();
    chk("daa_v0", 64'(o_ret_vld), 64'(1));
    chk("daa_d0", 64'(o_ret_data), 64'(0));
    i_alloc_info = mk(1, 1, 1, 0, 5'd4); step();
    i_alloc_vld = 0;
    chk("daa_v1", 64'(o_ret_vld), 64'(1));
    chk("daa_d1", 64'(o_ret_data), 64'(0));
    step();
    chk("daa_empty", 64'(o_lq_empty), 64'(1));
    i_ret_rdy = 0;

    // Response errors
    resp(5, 32'h77); step();
    i_resp_vld = 0;
    chk("err_unalloc", 64'(o_resp_err), 64'(1));
    chk("err_count",   64'(o_lq_count), 64'(0));
    step();
    chk("err_pulse", 64'(o_resp_err), 64'(0));
    i_alloc_vld = 1; i_alloc_info = mk(1, 0, 0, 0, 5'd9);
    chk("err_lqid", 64'(o_alloc_lqid), 64'(3)); step();
    i_alloc_vld = 0;
    resp(3, 32'h55); step();
    resp(3, 32'h99); step();
    i_resp_vld = 0;
    chk("err_done",  64'(o_resp_err), 64'(1));
    chk("err_data",  64'(o_ret_data), 64'(32'h55));
    i_ret_rdy = 1; step(); i_ret_rdy = 0;

    // Backpressure then reset with entries live
    info_bp = mk(1, 0, 0, 0, 5'd17);
    i_alloc_vld = 1; i_alloc_info = info_bp; step();
    i_alloc_vld = 0; resp(4, 32'hDEADBEEF); step();
    i_resp_vld = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", 64'(o_ret_data), 64'(32'hDEADBEEF));
      chk("bp_info", 64'(o_ret_info), 64'(info_bp));
      step();
    end
    i_ret_rdy = 1; step(); i_ret_rdy = 0;
    i_alloc_vld = 1; i_alloc_info = mk(1, 0, 0, 0, 5'd2);
    for (int i = 0; i < 4; i++) step();
    i_alloc_vld = 0;
    chk("pre_rst_count", 64'(o_lq_count), 64'(4));
    i_reset = 1; step(); i_reset = 0;
    chk("rst_mid_empty", 64'(o_lq_empty), 64'(1));
    resp(6, 32'h1); step();
    i_resp_vld = 0;
    chk("rst_late_err", 64'(o_resp_err), 64'(1));

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      i_reset      = ($urandom_range(0, 799) == 0);
      i_alloc_vld  = ($urandom_range(0, 99) < 55);
      i_alloc_info = lq_info_s'(11'($urandom));
      if ($urandom_range(0, 3) != 0) i_alloc_info.load = 1'b1;
      i_resp_vld   = ($urandom_range(0, 99) < 50);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        i_resp_lqid = AW'(mq[$urandom_range(0, mq.size() - 1)].id);
      else
        i_resp_lqid = AW'($urandom);
      i_resp_data  = $urandom;
      i_ret_rdy    = ($urandom_range(0, 99) < 60);
      step();
    end
    i_reset = 0; i_alloc_vld = 0; i_resp_vld = 0; i_ret_rdy = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
